// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Arbitrates NUM_REQ write requesters onto a single FIFO write port. A
// requester that wins a grant keeps ownership for up to MAX_BURST consecutive
// beats while it stays valid; otherwise the grant goes to the first valid
// requester found by a round-robin scan starting at rr_ptr. The grant path is
// combinational, so a beat can be written in the same cycle it is requested.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   reset_n        in   synchronous active-low reset
//   req_valid      in   [NUM_REQ]        requester i holds a beat
//   req_data       in   [NUM_REQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   req_ack        out  [NUM_REQ]        one-hot, beat of requester i accepted
//   fifo_ready     in   FIFO can accept a write this cycle
//   fifo_write_en  out  FIFO write strobe
//   fifo_data      out  [WIDTH]          FIFO write data
//   grant_idx      out  [3]              current grantee (0 when none)
//   grant_valid    out  a grantee exists this cycle
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 6,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ack,
    input  logic                     fifo_ready,
    output logic                     fifo_write_en,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [2:0]               grant_idx,
    output logic                     grant_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } mode_t;

    localparam logic [2:0] LAST_IDX  = 3'(NUM_REQ - 1);
    localparam logic [3:0] NUM_REQ_W = 4'(NUM_REQ);
    localparam logic [4:0] BURST_LEN = 5'(MAX_BURST);

    mode_t      mode_r;
    mode_t      mode_s;
    logic [2:0] owner_r;
    logic [2:0] owner_s;
    logic [3:0] beat_cnt_r;
    logic [3:0] beat_cnt_s;
    logic [2:0] rr_ptr_r;
    logic [2:0] rr_ptr_s;

    logic [7:0] valid_ext_s;
    logic       hold_s;
    logic       scan_found_s;
    logic [2:0] scan_idx_s;
    logic [3:0] scan_cand_s;
    logic [4:0] next_cnt_s;

    // Increment a requester index, wrapping at NUM_REQ rather than at 8.
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
        if (idx == LAST_IDX) begin
            return 3'd0;
        end else begin
            return idx + 3'd1;
        end
    endfunction

    // Grant selection: owner keeps the grant while valid, else round-robin scan.
    always_comb begin
        // Widening to 8 bits lets a 3-bit index address it for any NUM_REQ.
        valid_ext_s               = 8'd0;
        valid_ext_s[NUM_REQ-1:0]  = req_valid;
        hold_s                    = (mode_r == OWN) && valid_ext_s[owner_r];
        scan_found_s              = 1'b0;
        scan_idx_s                = 3'd0;
        scan_cand_s               = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr_r < NUM_REQ, so one conditional subtract is a full modulo.
            scan_cand_s = {1'b0, rr_ptr_r} + 4'(k);
            if (scan_cand_s >= NUM_REQ_W) begin
                scan_cand_s = scan_cand_s - NUM_REQ_W;
            end else begin
                scan_cand_s = scan_cand_s;
            end
            if (!scan_found_s && valid_ext_s[scan_cand_s[2:0]]) begin
                scan_found_s = 1'b1;
                scan_idx_s   = scan_cand_s[2:0];
            end else begin
                scan_found_s = scan_found_s;
            end
        end
        if (hold_s) begin
            grant_valid = 1'b1;
            grant_idx   = owner_r;
        end else begin
            grant_valid = scan_found_s;
            grant_idx   = scan_found_s ? scan_idx_s : 3'd0;
        end
    end

    // Write strobe, data mux and one-hot acknowledge for the grantee.
    always_comb begin
        fifo_write_en = grant_valid & fifo_ready & reset_n;
        fifo_data     = {WIDTH{1'b0}};
        req_ack       = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                fifo_data  = grant_valid ? req_data[i*WIDTH +: WIDTH] : {WIDTH{1'b0}};
                req_ack[i] = fifo_write_en;
            end else begin
                req_ack[i] = 1'b0;
            end
        end
    end

    // Next-state: release of an idle owner, then burst accounting on a beat.
    always_comb begin
        mode_s     = mode_r;
        owner_s    = owner_r;
        beat_cnt_s = beat_cnt_r;
        rr_ptr_s   = rr_ptr_r;
        // A newly chosen grantee counts from zero.
        next_cnt_s = (hold_s ? {1'b0, beat_cnt_r} : 5'd0) + 5'd1;
        if (!reset_n) begin
            mode_s     = IDLE;
            owner_s    = 3'd0;
            beat_cnt_s = 4'd0;
            rr_ptr_s   = 3'd0;
        end else begin
            // Owner went idle: release it and restart the scan after it. The
            // pointer update stands even if a new grantee beats this cycle.
            if ((mode_r == OWN) && !valid_ext_s[owner_r]) begin
                mode_s     = IDLE;
                beat_cnt_s = 4'd0;
                rr_ptr_s   = wrap_inc(owner_r);
            end else begin
                mode_s     = mode_r;
            end
            if (fifo_write_en) begin
                if (next_cnt_s < BURST_LEN) begin
                    mode_s     = OWN;
                    owner_s    = grant_idx;
                    beat_cnt_s = next_cnt_s[3:0];
                end else begin
                    mode_s     = IDLE;
                    beat_cnt_s = 4'd0;
                    rr_ptr_s   = wrap_inc(grant_idx);
                end
            end else begin
                owner_s = owner_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        mode_r     <= mode_s;
        owner_r    <= owner_s;
        beat_cnt_r <= beat_cnt_s;
        rr_ptr_r   <= rr_ptr_s;
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Self-checking bench. A behavioural model (integer mode/owner/count/pointer
// with modulo arithmetic) predicts every output of the main instance each
// cycle; scenario tasks add directed sequence checks. A second instance with
// NUM_REQ = 3 and MAX_BURST = 1 covers pure round-robin wrap.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 6;
    localparam int MB = 4;
    localparam int N3 = 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           fifo_ready;
    logic           fifo_write_en;
    logic [W-1:0]   fifo_data;
    logic [2:0]     grant_idx;
    logic           grant_valid;

    logic [N3-1:0]   req_valid3;
    logic [N3*W-1:0] req_data3;
    logic [N3-1:0]   req_ack3;
    logic            fifo_ready3;
    logic            fifo_write_en3;
    logic [W-1:0]    fifo_data3;
    logic [2:0]      grant_idx3;
    logic            grant_valid3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_own   = 1'b0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_rr    = 0;
    bit mon_en  = 1'b0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .fifo_ready(fifo_ready), .fifo_write_en(fifo_write_en),
        .fifo_data(fifo_data), .grant_idx(grant_idx), .grant_valid(grant_valid)
    );

    fifo_write_arbiter #(.NUM_REQ(N3), .WIDTH(W), .MAX_BURST(1)) dut3 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid3), .req_data(req_data3),
        .req_ack(req_ack3), .fifo_ready(fifo_ready3), .fifo_write_en(fifo_write_en3),
        .fifo_data(fifo_data3), .grant_idx(grant_idx3), .grant_valid(grant_valid3)
    );

    // Cycle monitor: predict all outputs of the main instance, then advance the model.
    always @(negedge clk) begin : monitor
        int         g;
        int         base;
        bit         hold;
        bit         e_gv;
        bit         e_we;
        int         e_gi;
        logic [W-1:0] e_data;
        logic [N-1:0] e_ack;
        if (mon_en) begin
            hold = m_own && req_valid[m_owner];
            g = -1;
            if (hold) begin
                g = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
                end
            end
            e_gv   = (g >= 0);
            e_gi   = e_gv ? g : 0;
            e_we   = e_gv && fifo_ready && reset_n;
            e_data = e_gv ? req_data[e_gi*W +: W] : '0;
            e_ack  = e_we ? N'(1 << g) : '0;
            checks++;
            if (grant_valid !== e_gv) begin
                errors++;
                $display("FAIL mon_grant_valid t=%0t got %b want %b", $time, grant_valid, e_gv);
            end
            checks++;
            if (grant_idx !== 3'(e_gi)) begin
                errors++;
                $display("FAIL mon_grant_idx t=%0t got %0d want %0d", $time, grant_idx, e_gi);
            end
            checks++;
            if (fifo_write_en !== e_we) begin
                errors++;
                $display("FAIL mon_write_en t=%0t got %b want %b", $time, fifo_write_en, e_we);
            end
            checks++;
            if (fifo_data !== e_data) begin
                errors++;
                $display("FAIL mon_fifo_data t=%0t got %h want %h", $time, fifo_data, e_data);
            end
            checks++;
            if (req_ack !== e_ack) begin
                errors++;
                $display("FAIL mon_req_ack t=%0t got %b want %b", $time, req_ack, e_ack);
            end
            // Model update for the coming rising edge
            if (!reset_n) begin
                m_own = 1'b0; m_owner = 0; m_cnt = 0; m_rr = 0;
            end else begin
                base = hold ? m_cnt : 0;
                if (m_own && !req_valid[m_owner]) begin
                    m_own = 1'b0; m_cnt = 0; m_rr = (m_owner + 1) % N;
                end
                if (e_we) begin
                    if (base + 1 < MB) begin
                        m_own = 1'b1; m_owner = g; m_cnt = base + 1;
                    end else begin
                        m_own = 1'b0; m_cnt = 0; m_rr = (g + 1) % N;
                    end
                end
            end
        end
    end

    task automatic next_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        next_edge();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        req_valid  = '1;
        req_data   = N*W'($urandom);
        fifo_ready = 1'b1;
        next_edge();
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ack !== 4'd0 || fifo_write_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet ack=%b we=%b want 0000/0", req_ack, fifo_write_en);
        end
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_grant gv=%b gi=%0d want 1/0", grant_valid, grant_idx);
        end
        next_edge();
    endtask

    task automatic test_burst_order;
        logic [N-1:0] exp_ack;
        do_reset();
        req_valid  = '1;
        fifo_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            exp_ack = (c < 16) ? N'(1 << (c / 4)) : 4'b0001;
            @(negedge clk);
            checks++;
            if (req_ack !== exp_ack) begin
                errors++;
                $display("FAIL burst_order cycle=%0d got %b want %b", c, req_ack, exp_ack);
            end
            next_edge();
            req_data = N*W'($urandom);
        end
    endtask

    task automatic test_ready_pulse;
        bit           rdy [4];
        logic [N-1:0] exp_ack;
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        req_valid = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            fifo_ready = rdy[c];
            exp_ack    = rdy[c] ? 4'b0100 : 4'b0000;
            @(negedge clk);
            checks++;
            if (req_ack !== exp_ack || fifo_write_en !== rdy[c]) begin
                errors++;
                $display("FAIL ready_pulse cycle=%0d ack=%b we=%b want %b/%b",
                         c, req_ack, fifo_write_en, exp_ack, rdy[c]);
            end
            next_edge();
        end
        fifo_ready = 1'b1;
    endtask

    task automatic test_release;
        do_reset();
        fifo_ready = 1'b1;
        req_valid  = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (req_ack !== 4'b0010) begin
                errors++;
                $display("FAIL release_owner_beat cycle=%0d got %b want 0010", c, req_ack);
            end
            next_edge();
        end
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b1000) begin
            errors++;
            $display("FAIL release_same_cycle got %b want 1000", req_ack);
        end
        next_edge();
        // With the pointer moved to 2 the scan must pick req2 ahead of req0.
        req_valid  = 4'b0101;
        fifo_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (grant_idx !== 3'd2 || grant_valid !== 1'b1 || req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL release_rr_ptr gi=%0d gv=%b ack=%b want 2/1/0000",
                     grant_idx, grant_valid, req_ack);
        end
        next_edge();
        fifo_ready = 1'b1;
    endtask

    task automatic test_wrap;
        logic [N3-1:0] exp_ack;
        reset_n     = 1'b0;
        req_valid3  = '1;
        fifo_ready3 = 1'b1;
        next_edge();
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            exp_ack = N3'(1 << (c % 3));
            @(negedge clk);
            checks++;
            if (req_ack3 !== exp_ack) begin
                errors++;
                $display("FAIL wrap3 cycle=%0d got %b want %b", c, req_ack3, exp_ack);
            end
            next_edge();
        end
        req_valid3 = '0;
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        fifo_ready = 1'b1;
        req_valid  = 4'b0010;
        next_edge();
        next_edge();
        reset_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (req_ack !== 4'b0000 || fifo_write_en !== 1'b0) begin
                errors++;
                $display("FAIL mid_burst_reset cycle=%0d ack=%b we=%b want 0000/0",
                         c, req_ack, fifo_write_en);
            end
            next_edge();
        end
        reset_n   = 1'b1;
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL after_reset_first got %b want 0001", req_ack);
        end
        next_edge();
    endtask

    task automatic test_random;
        logic [N-1:0] last_ack;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            last_ack = req_ack;
            checks++;
            if ((req_ack & (req_ack - 4'd1)) !== 4'd0) begin
                errors++;
                $display("FAIL rand_onehot cycle=%0d ack=%b", c, req_ack);
            end
            next_edge();
            reset_n    = ($urandom_range(0, 49) != 0);
            fifo_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                // Requesters hold valid and data stable until acknowledged.
                if (!req_valid[i] || last_ack[i]) begin
                    req_valid[i]        = ($urandom_range(0, 2) != 0);
                    req_data[i*W +: W]  = W'($urandom);
                end
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        fifo_ready  = 1'b0;
        req_valid3  = '0;
        req_data3   = '0;
        fifo_ready3 = 1'b0;
        test_reset();
        test_burst_order();
        test_ready_pulse();
        test_release();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        @(negedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal range 2..8).
REQ-002 SHALL have parameter WIDTH, default 6, data width; matches the downstream FIFO width.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive beats per grant (legal range 1..15).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  bit i high = requester i holds a beat.
REQ-007 SHALL have port req_data  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ack  output  NUM_REQ  one-hot; bit i high = requester i's beat is accepted this cycle.
REQ-009 SHALL have port fifo_ready  input  1  FIFO tail entry empty, so a write is accepted this cycle.
REQ-010 SHALL have port fifo_write_en  output  1  write strobe to the FIFO.
REQ-011 SHALL have port fifo_data  output  WIDTH  data to the FIFO.
REQ-012 SHALL have port grant_idx  output  3  index of the current grantee; valid only when grant_valid is high.
REQ-013 SHALL have port grant_valid  output  1  a requester is granted this cycle.

Function
REQ-014 SHALL hold state: mode (IDLE/OWN), owner (3b), beat_cnt (4b) and rr_ptr (3b).
REQ-015 In IDLE, or in OWN with req_valid[owner] low, the grantee SHALL be the first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ; combinational, zero-cycle latency.
REQ-016 In OWN with req_valid[owner] high, the grantee SHALL be owner regardless of other requests.
REQ-017 grant_valid SHALL be high iff a grantee exists; if none, grant_idx = 0.
REQ-018 fifo_write_en SHALL equal grant_valid AND fifo_ready AND reset_n; a write is never issued while fifo_ready is low.
REQ-019 fifo_data SHALL equal the grantee's req_data whenever grant_valid is high, else all zeros.
REQ-020 req_ack[grant_idx] SHALL equal fifo_write_en; all other req_ack bits SHALL be 0. A requester holds valid/data stable until acked.
REQ-021 A beat SHALL be the event fifo_write_en = 1 at a rising edge.
REQ-022 On a beat with beat_cnt+1 < MAX_BURST: mode = OWN, owner = grantee, beat_cnt = beat_cnt+1 (0 when the grantee is newly chosen, then +1).
REQ-023 On a beat that completes MAX_BURST beats: mode = IDLE, beat_cnt = 0, rr_ptr = (grantee+1) mod NUM_REQ.
REQ-024 In OWN with req_valid[owner] low at an edge: owner SHALL be released (mode IDLE, beat_cnt 0, rr_ptr = owner+1 mod NUM_REQ), unless a beat by a newly selected grantee occurs in the same cycle; in that case REQ-022/023 apply to the new grantee.
REQ-025 With fifo_ready low and no beat, all state SHALL hold, except the release in REQ-024.
REQ-026 With MAX_BURST = 1, every beat SHALL return to IDLE and advance rr_ptr (pure round-robin).
REQ-027 rr_ptr and owner increments SHALL wrap modulo NUM_REQ, not modulo 8.

Reset
REQ-028 While reset_n is low at an edge: mode = IDLE, owner = 0, beat_cnt = 0, rr_ptr = 0.
REQ-029 While reset_n is low: fifo_write_en = 0 and req_ack = 0; grant outputs follow REQ-015 from reset state.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no ack; the first grant after reset starts the scan from requester 0.

Verification
REQ-031 All 4 valid, fifo_ready = 1, MAX_BURST = 4 -> acks go 4x req0, 4x req1, 4x req2, 4x req3, then req0; beat order is exact.
REQ-032 req2 alone valid, fifo_ready pulses 1,0,0,1 -> exactly 2 acks, on cycles 0 and 3; fifo_write_en never high while fifo_ready is low.
REQ-033 Owner req1 drops valid after 2 beats while req3 is valid -> req3 acked in the same cycle; rr_ptr becomes 2 after the release.
REQ-034 NUM_REQ = 3, MAX_BURST = 1, all valid -> ack sequence 0,1,2,0,1,2 (wrap at 3).
REQ-035 Reset during beat 3 of a req1 burst -> no acks while in reset; after release with all requests valid, first ack is to req0.
REQ-036 Check every cycle: fifo_data = req_data[grant_idx] when fifo_write_en = 1, and req_ack is one-hot or zero.
